// File: rtl/dir_scheduler_pkg.sv
// Shared direction encoding, reversal helper and scheduler state type.
package dir_scheduler_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } sched_state_t;

    // Opposite directions differ only in bit 0.
    function automatic dir_t reverse(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular buffer of directions; push into a full buffer succeeds only alongside a pop.
// Head/tail are combinational reads of the stored entries.
module dir_fifo
    import dir_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  dir_t             push_dat,
    input  logic             pop,
    output dir_t             head,
    output dir_t             tail,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    dir_t             mem_q [DEPTH];
    dir_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign tail_ptr = wr_q - PTR_W'(1);
    assign head     = mem_q[rd_q];
    assign tail     = mem_q[tail_ptr];
    assign level    = level_q;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: DIR_UP};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/dir_scheduler.sv
// Queues reversal-safe direction presses and releases one per game step derived from frame strobes.
// DIR_QUEUE_EN selects a DEPTH-entry FIFO; otherwise a single overwrite-on-press pending slot is used.
module dir_scheduler
    import dir_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SPD_W = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_left,
    input  logic             i_right,
    input  logic             i_frame,
    input  logic [SPD_W-1:0] i_speed,
    input  logic             i_alive,
    output logic             o_step,
    output logic [1:0]       o_dir,
    output logic             o_start,
    output logic [LVL_W-1:0] o_level
);

    logic [3:0]       btn_q, btn_d;
    logic [3:0]       press;
    logic             cand_vld_q, cand_vld_d;
    dir_t             cand_dir_q, cand_dir_d;
    sched_state_t     state_q, state_d;
    logic [SPD_W-1:0] cnt_q, cnt_d;
    logic             o_step_q, o_step_d;
    dir_t             o_dir_q, o_dir_d;
    logic             o_start_q, o_start_d;

    dir_t             ref_dir;
    dir_t             head_dir;
    logic             q_empty;
    logic             accept;
    logic             push_req;
    logic             step_fire;

    // Press detection is registered, so a candidate is judged one cycle after its edge.
    always_comb begin
        btn_d      = {i_up, i_down, i_left, i_right};
        press      = btn_d & ~btn_q;
        cand_vld_d = |press;
        cand_dir_d = DIR_RIGHT;
        if (press[3])      cand_dir_d = DIR_UP;
        else if (press[2]) cand_dir_d = DIR_DOWN;
        else if (press[1]) cand_dir_d = DIR_LEFT;
    end

    assign accept = cand_vld_q
                 && (cand_dir_q != ref_dir)
                 && (cand_dir_q != reverse(ref_dir));

    // Blocking on o_step_q keeps steps at least one cycle apart even with a stuck frame strobe.
    assign step_fire = (state_q == RUN) && i_alive && i_frame && !o_step_q
                    && (cnt_q >= i_speed);

`ifdef DIR_QUEUE_EN
    dir_t             tail_dir;
    logic             q_full;
    logic [LVL_W-1:0] q_level;

    assign ref_dir  = q_empty ? o_dir_q : tail_dir;
    assign push_req = accept && (state_q != DEAD) && (!q_full || step_fire);

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_dir_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .push_dat (cand_dir_q),
        .pop      (step_fire),
        .head     (head_dir),
        .tail     (tail_dir),
        .level    (q_level),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign o_level = q_level;
`else
    logic pend_vld_q, pend_vld_d;
    dir_t pend_dir_q, pend_dir_d;

    assign ref_dir  = o_dir_q;
    assign push_req = accept && (state_q != DEAD);

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        if (push_req) begin
            pend_vld_d = 1'b1;
            pend_dir_d = cand_dir_q;
        end else if (step_fire) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_UP;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
        end
    end

    assign head_dir = pend_dir_q;
    assign q_empty  = !pend_vld_q;
    assign o_level  = LVL_W'(pend_vld_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        o_step_d  = step_fire;
        o_dir_d   = o_dir_q;
        o_start_d = o_start_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (push_req) begin
                    state_d   = RUN;
                    o_start_d = 1'b1;
                end
            end
            RUN: begin
                if (!i_alive) begin
                    state_d = DEAD;
                end else if (i_frame && !o_step_q) begin
                    cnt_d = step_fire ? '0 : cnt_q + SPD_W'(1);
                end
            end
            DEAD:    state_d = DEAD;
            default: state_d = IDLE;
        endcase
        if (step_fire && !q_empty) begin
            o_dir_d = head_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q      <= '0;
            cand_vld_q <= 1'b0;
            cand_dir_q <= DIR_UP;
            state_q    <= IDLE;
            cnt_q      <= '0;
            o_step_q   <= 1'b0;
            o_dir_q    <= DIR_LEFT;
            o_start_q  <= 1'b0;
        end else begin
            btn_q      <= btn_d;
            cand_vld_q <= cand_vld_d;
            cand_dir_q <= cand_dir_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_step_q   <= o_step_d;
            o_dir_q    <= o_dir_d;
            o_start_q  <= o_start_d;
        end
    end

    assign o_step  = o_step_q;
    assign o_dir   = o_dir_q;
    assign o_start = o_start_q;

endmodule
